// File: rtl/updn_cnt_pkg.sv
// Shared types for the parametrised up/down counter and the transaction layout
// used by benches that drive it.
package updn_cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    // Reference configuration the verification benches build against.
    localparam int CNT_TXN_WIDTH  = 4;
    localparam int CNT_TXN_MOD    = 10;
    localparam int CNT_TXN_STEP_W = 3;

    typedef struct packed {
        logic                      load;
        logic [CNT_TXN_WIDTH-1:0]  load_val;
        logic                      en;
        cnt_dir_e                  dir;
        logic [CNT_TXN_STEP_W-1:0] step;
        cnt_mode_e                 mode;
        logic                      clr_flags;
    } cnt_txn_t;

endpackage

// File: rtl/updn_next_val.sv
// Combinational next-count computation: applies one step up or down and reports
// whether the bound was crossed, wrapping or saturating as selected.
module updn_next_val
    import updn_cnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MOD_VAL = 2**WIDTH,
    parameter int STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  next_q,
    output logic              wrap,
    output logic              ovf,
    output logic              unf
);

    // One extra bit so q+step and q+MOD_VAL never truncate before the compare.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MOD_VAL);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD_VAL - 1);

    cnt_dir_e        dir;
    cnt_mode_e       mode;
    logic [WIDTH:0]  q_ext;
    logic [WIDTH:0]  step_ext;
    logic [WIDTH:0]  sum;

    assign dir      = cnt_dir_e'(up);
    assign mode     = cnt_mode_e'(sat_mode);
    assign q_ext    = {1'b0, q};
    assign step_ext = (WIDTH+1)'(step);
    assign sum      = q_ext + step_ext;

    always_comb begin
        next_q = q;
        wrap   = 1'b0;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (dir == CNT_UP) begin
            if (sum <= MAX_EXT) begin
                next_q = WIDTH'(sum);
            end else begin
                ovf = 1'b1;
                if (mode == CNT_SAT) begin
                    next_q = WIDTH'(MAX_EXT);
                end else begin
                    next_q = WIDTH'(sum - MOD_EXT);
                    wrap   = 1'b1;
                end
            end
        end else begin
            if (step_ext <= q_ext) begin
                next_q = WIDTH'(q_ext - step_ext);
            end else begin
                unf = 1'b1;
                if (mode == CNT_SAT) begin
                    next_q = '0;
                end else begin
                    next_q = WIDTH'(q_ext + MOD_EXT - step_ext);
                    wrap   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with modulus, step, wrap/saturate mode,
// synchronous load, bound flags, wrap pulse and sticky overflow/underflow.
module updn_counter_param
    import updn_cnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MOD_VAL = 2**WIDTH,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  q,
    output logic              at_max,
    output logic              at_min,
    output logic              wrap_p,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD_VAL - 1);

    generate
        if (MOD_VAL < 2 || MOD_VAL > 2**WIDTH) begin : g_bad_mod
            $error("updn_counter_param: MOD_VAL must lie in 2..2**WIDTH");
        end
        if (2**STEP_W > MOD_VAL) begin : g_bad_step
            $error("updn_counter_param: 2**STEP_W must not exceed MOD_VAL");
        end
    endgenerate

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_q;
    logic             nv_wrap;
    logic             nv_ovf;
    logic             nv_unf;
    logic             count_en;

    updn_next_val #(
        .WIDTH   (WIDTH),
        .MOD_VAL (MOD_VAL),
        .STEP_W  (STEP_W)
    ) u_next_val (
        .q        (q),
        .step     (step),
        .up       (up),
        .sat_mode (sat_mode),
        .next_q   (next_q),
        .wrap     (nv_wrap),
        .ovf      (nv_ovf),
        .unf      (nv_unf)
    );

    // Out-of-range load values are clamped rather than reduced modulo.
    assign load_q   = ({1'b0, load_val} > MAX_EXT) ? WIDTH'(MAX_EXT) : load_val;
    assign count_en = en & ~load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            wrap_p     <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            if (load) begin
                q <= load_q;
            end else if (en) begin
                q <= next_q;
            end
            wrap_p     <= count_en & nv_wrap;
            // A fresh event on the clearing edge wins over the clear.
            ovf_sticky <= (count_en & nv_ovf) | (ovf_sticky & ~clr_flags);
            unf_sticky <= (count_en & nv_unf) | (unf_sticky & ~clr_flags);
        end
    end

    assign at_max = ({1'b0, q} == MAX_EXT);
    assign at_min = (q == '0);

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param (WIDTH=4, MOD_VAL=10, STEP_W=3):
// directed scenarios followed by random traffic against an arithmetic model.
module tb_updn_counter_param;
    import updn_cnt_pkg::*;

    localparam int W  = CNT_TXN_WIDTH;
    localparam int M  = CNT_TXN_MOD;
    localparam int SW = CNT_TXN_STEP_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          up = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [SW-1:0] step = '0;
    logic          sat_mode = 1'b0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  q;
    logic          at_max;
    logic          at_min;
    logic          wrap_p;
    logic          ovf_sticky;
    logic          unf_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    int m_q   = 0;
    int m_wrap = 0;
    int m_ovf = 0;
    int m_unf = 0;

    updn_counter_param #(
        .WIDTH   (W),
        .MOD_VAL (M),
        .STEP_W  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .step       (step),
        .sat_mode   (sat_mode),
        .clr_flags  (clr_flags),
        .q          (q),
        .at_max     (at_max),
        .at_min     (at_min),
        .wrap_p     (wrap_p),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Reference behaviour of one clock edge, computed with plain integers.
    task automatic model_edge();
        int s;
        int ov;
        int un;
        int wr;
        ov = 0; un = 0; wr = 0;
        if (load) begin
            m_q = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
        end else if (en) begin
            if (up) begin
                s = m_q + int'(step);
                if (s > M - 1) begin
                    ov = 1;
                    if (sat_mode) m_q = M - 1;
                    else begin m_q = s - M; wr = 1; end
                end else m_q = s;
            end else begin
                s = m_q - int'(step);
                if (s < 0) begin
                    un = 1;
                    if (sat_mode) m_q = 0;
                    else begin m_q = s + M; wr = 1; end
                end else m_q = s;
            end
        end
        m_wrap = wr;
        m_ovf  = (ov != 0 || (m_ovf != 0 && !clr_flags)) ? 1 : 0;
        m_unf  = (un != 0 || (m_unf != 0 && !clr_flags)) ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},      int'(q),          m_q);
        chk({tag, ".at_max"}, int'(at_max),     (m_q == M - 1) ? 1 : 0);
        chk({tag, ".at_min"}, int'(at_min),     (m_q == 0) ? 1 : 0);
        chk({tag, ".wrap_p"}, int'(wrap_p),     m_wrap);
        chk({tag, ".ovf"},    int'(ovf_sticky), m_ovf);
        chk({tag, ".unf"},    int'(unf_sticky), m_unf);
    endtask

    task automatic drive(input logic l, input int lv, input logic e, input logic u,
                         input int st, input logic sm, input logic cf);
        load = l; load_val = W'(lv); en = e; up = u;
        step = SW'(st); sat_mode = sm; clr_flags = cf;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all({tag, "_held"});
    endtask

    cnt_txn_t txn;

    initial begin
        async_reset("reset");

        // 1: count to 6 then reset mid-cycle
        drive(0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle("t1_up");
        chk("t1_q6", int'(q), 6);
        async_reset("t1_rst");

        // 2: wrap from 8 by 3
        drive(1, 8, 0, 0, 0, 0, 0); cycle("t2_load");
        drive(0, 0, 1, 1, 3, 0, 0); cycle("t2_wrap");
        chk("t2_q1", int'(q), 1);
        drive(0, 0, 0, 1, 3, 0, 0); cycle("t2_pulse_end");

        // 3: saturate below zero, twice
        drive(1, 2, 0, 0, 0, 1, 0); cycle("t3_load");
        drive(0, 0, 1, 0, 5, 1, 0); cycle("t3_sat");
        cycle("t3_sat2");
        chk("t3_q0", int'(q), 0);

        // 4: clamped load with en asserted, then step 0 holds
        drive(1, 12, 1, 1, 7, 0, 0); cycle("t4_clamp");
        chk("t4_q9", int'(q), 9);
        drive(0, 9, 1, 1, 0, 0, 0); cycle("t4_hold");

        // 5: clear coincident with a new overflow, then plain clear
        drive(0, 0, 1, 1, 1, 0, 1); cycle("t5_clr_set");
        chk("t5_ovf_kept", int'(ovf_sticky), 1);
        drive(0, 0, 0, 1, 1, 0, 1); cycle("t5_clr");
        chk("t5_ovf_clr", int'(ovf_sticky), 0);

        // 6: full wrap lap from reset, then one step down through zero
        drive(0, 0, 0, 0, 0, 0, 0);
        async_reset("t6_rst");
        drive(0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle("t6_lap");
        chk("t6_wrap_last", int'(wrap_p), 1);
        drive(0, 0, 1, 0, 1, 0, 0); cycle("t6_down");
        chk("t6_q9", int'(q), 9);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            txn.load      = ($urandom_range(7) == 0);
            txn.load_val  = W'($urandom_range(15));
            txn.en        = ($urandom_range(3) != 0);
            txn.dir       = cnt_dir_e'($urandom_range(1));
            txn.step      = SW'($urandom_range(7));
            txn.mode      = cnt_mode_e'($urandom_range(1));
            txn.clr_flags = ($urandom_range(7) == 0);
            drive(txn.load, int'(txn.load_val), txn.en, txn.dir, int'(txn.step),
                  txn.mode, txn.clr_flags);
            if ($urandom_range(63) == 0) async_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updn_counter_param.md
Name: updn_counter_param

Overview:
Parametrised successor to the single-bit-direction up/down counter. It provides a configurable modulus, programmable step size, and a run-time selectable wrap or saturate mode. It also adds synchronous load, bound flags, a wrap pulse, and sticky overflow/underflow flags. It sits as a general-purpose event/position counter used by the team's verification benches and datapath control.

Parameters:
WIDTH, 8, bit width of count output q.
MOD_VAL, 2**WIDTH, count range is 0..MOD_VAL-1. Constraint: 2 <= MOD_VAL <= 2**WIDTH.
STEP_W, 4, width of step input. Constraint: 2**STEP_W <= MOD_VAL; checked by elaboration-time assertion.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable.
up  in  1  direction: 1 = count up, 0 = count down.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value to load.
step  in  STEP_W  increment/decrement amount; 0 = hold.
sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MOD_VAL.
clr_flags  in  1  clears ovf_sticky/unf_sticky.
q  out  WIDTH  current count.
at_max  out  1  q == MOD_VAL-1 (combinational from q register).
at_min  out  1  q == 0 (combinational from q register).
wrap_p  out  1  registered one-cycle pulse: a wrap occurred on the last edge.
ovf_sticky  out  1  set on any up-count crossing MOD_VAL-1 (wrap or saturate).
unf_sticky  out  1  set on any down-count crossing below 0 (wrap or saturate).

Behaviour:
- Reset, asynchronous on rst high: q=0, wrap_p=0, ovf_sticky=0, unf_sticky=0, hence at_min=1, at_max=0. Reset held overrides all inputs. Deassertion is synchronised by the integrator, not in this block.
- Priority per edge: rst > load > en. en=0 or step=0 (without load) holds q. wrap_p then drops to 0.
- Load: q <= min(load_val, MOD_VAL-1). No flags set, wrap_p=0, step/up ignored.
- Latency: q reflects inputs sampled at edge N immediately after edge N. wrap_p and stickies update on the same edge.
- Arithmetic uses WIDTH+1 internal bits; no truncation before bound checks. MAX = MOD_VAL-1.
- Up, en=1:
  - sum = q + step.
  - If sum <= MAX: q <= sum.
  - Else in sat_mode: q <= MAX, ovf_sticky <= 1, wrap_p=0.
  - Else in wrap mode: q <= sum - MOD_VAL, wrap_p <= 1, ovf_sticky <= 1.
- Down, en=1:
  - If step <= q: q <= q - step.
  - Else in sat_mode: q <= 0, unf_sticky <= 1.
  - Else in wrap mode: q <= q + MOD_VAL - step, wrap_p <= 1, unf_sticky <= 1.
- Exact landing on MAX or 0 is not an overflow or underflow.
- Saturated at MAX with further up-counts: q holds and ovf_sticky is re-set each cycle. Symmetric rule for down-counts at 0.
- clr_flags: clears both stickies on the edge. If a new ovf/unf event occurs on the same edge, set wins for that flag.
- sat_mode may change any cycle; it takes effect on the next edge.

Decomposition:
- Package updn_cnt_pkg:
  - typedef enum logic {CNT_WRAP=0, CNT_SAT=1} cnt_mode_e.
  - typedef enum logic {CNT_DOWN=0, CNT_UP=1} cnt_dir_e.
  - Shared transaction field widths for the bench's interface/generator.
- Sub-module updn_next_val: purely combinational. Takes q, step, up, sat_mode. Produces next_q, wrap, ovf, unf. The top holds registers, load/priority and sticky logic.

Test Plan (WIDTH=4, MOD_VAL=10, STEP_W=3):
1. Count up to 6, assert rst between clock edges -> q=0, at_min=1, stickies=0 immediately, before next edge.
2. Load 8, then en=1 up=1 step=3 sat_mode=0 -> q=1, wrap_p=1 for exactly one cycle, ovf_sticky=1.
3. Load 2, then en=1 up=0 step=5 sat_mode=1 -> q=0, unf_sticky=1, at_min=1, wrap_p=0. A second identical cycle keeps q=0.
4. load=1 en=1 load_val=12 step=7 -> q=9 (clamped), at_max=1, no flags; load_val=9 up step=0 -> q=9 held.
5. With ovf_sticky=1, assert clr_flags with a simultaneous up-wrap from 9 step 1 -> ovf_sticky remains 1, q=0. Next cycle clr_flags alone -> ovf_sticky=0.
6. From reset, en=1 up=1 step=1 sat_mode=0 for 10 edges -> q goes 1..9 then 0, with wrap_p high only after the 10th edge. Then up=0 for 1 edge -> q=9, unf_sticky=1.
